bcd_count_ctrl: RTL

Sequencing controller for the 0–9999 counter display path.
- Replaces the divided-clock approach with single-cycle enable ticks on the one system clock.
- Runs a start/stop/clear state machine and steps a 4-digit BCD count.
- Time-multiplexes the four digits onto a shared 7-segment decoder input.
- Sits between debounced push-buttons and the segment decoder / anode drivers.

---
 rtl/bcd_count_ctrl_if.sv | 22 ++
 rtl/bcd_count_ctrl.sv | 83 ++++++++
 2 files changed

// File: rtl/bcd_count_ctrl_if.sv
// bcd_count_ctrl_if: command/display bundle for bcd_count_ctrl.
//   i_start, i_stop, i_clear : single-cycle debounced command pulses
//   i_dir                    : count direction, 1 = down (only with BCD_COUNT_CTRL_DOWN_EN)
//   o_bcd                    : 4-digit BCD count, thousands in [15:12]
//   o_digit, o_an            : scanned digit value and active-low anode select
//   o_running, o_ovf         : RUN indicator and one-cycle 9999/0000 boundary pulse
interface bcd_count_ctrl_if;
   logic        i_start, i_stop, i_clear;
`ifdef BCD_COUNT_CTRL_DOWN_EN
   logic        i_dir;
`endif
   logic [15:0] o_bcd;
   logic [3:0]  o_digit, o_an;
   logic        o_running, o_ovf;
`ifdef BCD_COUNT_CTRL_DOWN_EN
   modport master(output i_start, i_stop, i_clear, i_dir, input o_bcd, o_digit, o_an, o_running, o_ovf);
   modport slave(input i_start, i_stop, i_clear, i_dir, output o_bcd, o_digit, o_an, o_running, o_ovf);
`else
   modport master(output i_start, i_stop, i_clear, input o_bcd, o_digit, o_an, o_running, o_ovf);
   modport slave(input i_start, i_stop, i_clear, output o_bcd, o_digit, o_an, o_running, o_ovf);
`endif
endinterface

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: start/stop/clear sequencer for a 0-9999 BCD counter with 4-digit display scan.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : bcd_count_ctrl_if.slave (commands in, count/scan/status out)
//   Optional macro BCD_COUNT_CTRL_DOWN_EN adds bus.i_dir for down counting.
module bcd_count_ctrl #(
   parameter int TICK_DIV = 500000,
   parameter int SCAN_DIV = 50000,
   parameter bit WRAP     = 1'b1
) (
   input logic clk,
   input logic rst,
   bcd_count_ctrl_if.slave bus
);
   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, HOLD} state_t;
   state_t        r_state, w_next;
   logic [TW-1:0] r_tick_cnt;
   logic [SW-1:0] r_scan_cnt;
   logic [15:0]   r_bcd, w_step;
   logic [3:0]    r_an;
   logic          r_running, r_ovf;
   logic          w_down, w_tick, w_bound, w_sat, w_c, w_scan_wrap;
`ifdef BCD_COUNT_CTRL_DOWN_EN
   assign w_down = bus.i_dir;
`else
   assign w_down = 1'b0;
`endif
   assign w_tick      = (r_state == RUN) && (r_tick_cnt == TW'(TICK_DIV - 1));
   assign w_bound     = w_down ? (r_bcd == 16'h0000) : (r_bcd == 16'h9999);
   assign w_sat       = w_tick && w_bound && !WRAP;
   assign w_scan_wrap = r_scan_cnt == SW'(SCAN_DIV - 1);
   // Ripple carry/borrow across digits; at the boundary this naturally yields the wrapped value.
   always_comb begin
      w_c    = 1'b1;
      w_step = r_bcd;
      for (int k = 0; k < 4; k++) begin
         w_step[4*k +: 4] = !w_c ? r_bcd[4*k +: 4] :
                            w_down ? (r_bcd[4*k +: 4] == 4'd0 ? 4'd9 : r_bcd[4*k +: 4] - 4'd1) :
                                     (r_bcd[4*k +: 4] == 4'd9 ? 4'd0 : r_bcd[4*k +: 4] + 4'd1);
         w_c = w_c && (r_bcd[4*k +: 4] == (w_down ? 4'd0 : 4'd9));
      end
   end
   // Commands rank clear > stop > start; saturation outranks a coincident stop.
   always_comb begin
      w_next = r_state;
      if (bus.i_clear) w_next = IDLE;
      else if (r_state == IDLE) w_next = (bus.i_start && !bus.i_stop) ? RUN : IDLE;
      else if (r_state == RUN) w_next = w_sat ? HOLD : bus.i_stop ? PAUSE : RUN;
      else if (r_state == PAUSE) w_next = (bus.i_start && !bus.i_stop) ? RUN : PAUSE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_bcd      <= 16'h0000;
         r_tick_cnt <= '0;
         r_scan_cnt <= '0;
         r_an       <= 4'b1110;
         r_running  <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_running  <= w_next == RUN;
         r_ovf      <= w_tick && w_bound && !bus.i_clear;
         r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
         if (w_scan_wrap) r_an <= {r_an[2:0], r_an[3]};
         if (bus.i_clear) begin
            r_bcd      <= 16'h0000;
            r_tick_cnt <= '0;
         end else if (w_tick) begin
            r_bcd      <= w_sat ? r_bcd : w_step;
            r_tick_cnt <= '0;
         end else if (r_state == RUN && !bus.i_stop) r_tick_cnt <= r_tick_cnt + TW'(1);
         else if (r_state == IDLE) r_tick_cnt <= '0;
      end
   end
   assign bus.o_bcd     = r_bcd;
   assign bus.o_an      = r_an;
   assign bus.o_running = r_running;
   assign bus.o_ovf     = r_ovf;
   assign bus.o_digit   = !r_an[0] ? r_bcd[3:0] : !r_an[1] ? r_bcd[7:4] : !r_an[2] ? r_bcd[11:8] : r_bcd[15:12];
endmodule
